// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce, hex decode
// and a two-digit key history for the seven-segment display path.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 24000,
  parameter int unsigned DEBOUNCE_CNT = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic [3:0] digit0,
  output logic [3:0] digit1
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CNT);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_CNT - 1);
  // Nibble {row, col} holds the legend of that key.
  localparam logic [63:0] KeyTable = 64'hDF0E_C987_B654_A321;

  typedef enum logic [1:0] {StScan, StPressDb, StHeld, StRelDb} state_e;

  state_e            state_q;
  logic [3:0]        rs_meta_q, rs_q;
  logic [1:0]        ci_q;
  logic [DwellW-1:0] dwell_q;
  logic [DbW-1:0]    db_q;
  logic [3:0]        row_q;
  logic [3:0]        cols_q, key_q, digit0_q, digit1_q;
  logic              key_valid_q;

  logic [1:0] ci_inc;
  logic       row_held;
  logic [3:0] key_code;

  function automatic logic one_active(input logic [3:0] v);
    return v inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  endfunction

  function automatic logic [3:0] key_map(input logic [3:0] pat, input logic [1:0] c);
    logic [1:0] r;
    case (pat)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    return KeyTable[4 * {r, c} +: 4];
  endfunction

  assign ci_inc   = ci_q + 2'd1;
  // The captured pattern has a single 0; OR-ing exposes whether that row is still low.
  assign row_held = (rs_q | row_q) != 4'b1111;
  assign key_code = key_map(row_q, ci_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StScan;
      rs_meta_q   <= 4'b1111;
      rs_q        <= 4'b1111;
      ci_q        <= 2'd0;
      dwell_q     <= '0;
      db_q        <= '0;
      row_q       <= 4'b1111;
      cols_q      <= 4'b1110;
      key_q       <= 4'h0;
      digit0_q    <= 4'h0;
      digit1_q    <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      rs_meta_q   <= rows;
      rs_q        <= rs_meta_q;
      key_valid_q <= 1'b0;
      unique case (state_q)
        StScan: begin
          if (dwell_q == DwellLast) begin
            dwell_q <= '0;
            if (one_active(rs_q)) begin
              row_q   <= rs_q;
              db_q    <= '0;
              state_q <= StPressDb;
            end else begin
              ci_q   <= ci_inc;
              cols_q <= ~(4'b0001 << ci_inc);
            end
          end else begin
            dwell_q <= dwell_q + DwellW'(1);
          end
        end
        StPressDb: begin
          if (rs_q != row_q) begin
            state_q <= StScan;
            ci_q    <= ci_inc;
            cols_q  <= ~(4'b0001 << ci_inc);
            db_q    <= '0;
            dwell_q <= '0;
          end else if (db_q == DbLast) begin
            state_q     <= StHeld;
            db_q        <= '0;
            key_q       <= key_code;
            digit0_q    <= key_code;
            digit1_q    <= digit0_q;
            key_valid_q <= 1'b1;
          end else begin
            db_q <= db_q + DbW'(1);
          end
        end
        StHeld: begin
          if (!row_held) begin
            state_q <= StRelDb;
            db_q    <= '0;
          end
        end
        StRelDb: begin
          if (row_held) begin
            state_q <= StHeld;
            db_q    <= '0;
          end else if (db_q == DbLast) begin
            state_q <= StScan;
            ci_q    <= ci_inc;
            cols_q  <= ~(4'b0001 << ci_inc);
            db_q    <= '0;
            dwell_q <= '0;
          end else begin
            db_q <= db_q + DbW'(1);
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

  assign cols      = cols_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign digit0    = digit0_q;
  assign digit1    = digit1_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from cols, a behavioural
// reference is compared every cycle, and directed scenarios pin literal values.
module tb_keypad_scanner;

  localparam int ScanDiv = 4;
  localparam int DbCnt   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows, cols, key, digit0, digit1;
  logic       key_valid;
  logic [15:0] pressed = '0;  // bit r*4+c is key at row r, column c

  int errors  = 0;
  int checks  = 0;
  int kv_seen = 0;

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  always #5 clk = ~clk;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && cols[c] === 1'b0) rows[r] = 1'b0;
  end

  keypad_scanner #(.SCAN_DIV(ScanDiv), .DEBOUNCE_CNT(DbCnt)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .digit0    (digit0),
    .digit1    (digit1)
  );

  // Reference model: mode 0 scanning, 1 press debounce, 2 held, 3 release debounce.
  int         m_mode, m_dwell, m_db, m_row, m_ci;
  logic [3:0] m_meta, m_rs, m_key, m_d0, m_d1;
  logic       m_kv;

  task automatic model_reset();
    m_mode = 0; m_dwell = 0; m_db = 0; m_row = 0; m_ci = 0;
    m_meta = 4'hF; m_rs = 4'hF; m_key = 0; m_d0 = 0; m_d1 = 0; m_kv = 0;
  endtask

  task automatic model_step();
    logic [3:0] samp, pat;
    int         nact;
    samp = rows;
    m_kv = 1'b0;
    pat  = 4'hF & ~(4'd1 << m_row);
    case (m_mode)
      0: begin
        if (m_dwell == ScanDiv - 1) begin
          m_dwell = 0;
          nact = 0;
          for (int r = 3; r >= 0; r--) if (!m_rs[r]) begin nact++; m_row = r; end
          if (nact == 1) begin m_mode = 1; m_db = 0; end
          else m_ci = (m_ci + 1) % 4;
        end else m_dwell++;
      end
      1: begin
        if (m_rs != pat) begin
          m_mode = 0; m_ci = (m_ci + 1) % 4; m_db = 0; m_dwell = 0;
        end else begin
          m_db++;
          if (m_db == DbCnt) begin
            m_key = keymap[m_row*4 + m_ci];
            m_d1 = m_d0; m_d0 = m_key; m_kv = 1'b1;
            m_mode = 2; m_db = 0;
          end
        end
      end
      2: if (m_rs[m_row]) begin m_mode = 3; m_db = 0; end
      default: begin
        if (!m_rs[m_row]) begin m_mode = 2; m_db = 0; end
        else begin
          m_db++;
          if (m_db == DbCnt) begin m_mode = 0; m_ci = (m_ci + 1) % 4; m_dwell = 0; m_db = 0; end
        end
      end
    endcase
    m_rs = m_meta;
    m_meta = samp;
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) model_reset();
      check4("model cols", cols, 4'hF ^ (4'd1 << m_ci));
      check4("model key", key, m_key);
      check4("model digit0", digit0, m_d0);
      check4("model digit1", digit1, m_d1);
      check4("model key_valid", {3'b0, key_valid}, {3'b0, m_kv});
      if (key_valid === 1'b1) kv_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_kv(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc(1);
      if (key_valid === 1'b1) ok = 1'b1;
    end
    check_int({name, " key_valid seen"}, int'(ok), 1);
  endtask

  task automatic wait_cols_leave(input string name, input logic [3:0] from, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc(1);
      if (cols !== from) ok = 1'b1;
    end
    check_int({name, " cols moved"}, int'(ok), 1);
  endtask

  int base;

  initial begin
    cyc(3);
    // Reset state.
    check4("reset cols", cols, 4'b1110);
    check4("reset key", key, 4'h0);
    check4("reset digit0", digit0, 4'h0);
    check4("reset digit1", digit1, 4'h0);
    check4("reset key_valid", {3'b0, key_valid}, 4'h0);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      check4("rotate cols", cols, 4'hF ^ (4'd1 << ((k / 4) % 4)));
    end

    // Single press "5", then "A" shifts history.
    base = kv_seen;
    pressed[5] = 1'b1;
    wait_kv("key5", 100);
    check4("key5 key", key, 4'h5);
    check4("key5 digit0", digit0, 4'h5);
    check4("key5 digit1", digit1, 4'h0);
    cyc(20);
    check4("key5 cols frozen", cols, 4'b1101);
    check_int("key5 pulses", kv_seen - base, 1);
    pressed = '0;
    cyc(20);
    pressed[3] = 1'b1;
    wait_kv("keyA", 100);
    check4("keyA digit0", digit0, 4'hA);
    check4("keyA digit1", digit1, 4'h5);
    pressed = '0;
    cyc(20);

    // Press bounce on "9".
    base = kv_seen;
    for (int i = 0; i < 10; i++) begin
      pressed[10] = ~pressed[10];
      cyc(3);
    end
    check_int("bounce pulses", kv_seen - base, 0);
    pressed[10] = 1'b1;
    wait_kv("key9", 200);
    check4("key9 key", key, 4'h9);
    cyc(15);
    check_int("key9 pulses", kv_seen - base, 1);
    pressed = '0;
    cyc(20);

    // Release bounce on "0".
    pressed[13] = 1'b1;
    wait_kv("key0", 100);
    check4("key0 key", key, 4'h0);
    base = kv_seen;
    cyc(5);
    for (int i = 0; i < 8; i++) begin
      pressed[13] = ~pressed[13];
      cyc(5);
    end
    check_int("relbounce pulses", kv_seen - base, 0);
    check4("relbounce cols", cols, 4'b1101);
    pressed = '0;
    wait_cols_leave("key0 release", 4'b1101, 60);
    check4("resume next column", cols, 4'b1011);

    // Multi-key.
    cyc(10);
    pressed[0] = 1'b1;
    wait_kv("key1", 100);
    check4("key1 key", key, 4'h1);
    base = kv_seen;
    pressed[8] = 1'b1;
    cyc(20);
    check_int("held ignores 7", kv_seen - base, 0);
    pressed = '0;
    wait_cols_leave("key1 release", 4'b1110, 60);
    pressed[2] = 1'b1;
    pressed[3] = 1'b1;
    wait_kv("key3A", 100);
    check4("key3A key", key, 4'h3);
    cyc(5);
    pressed = '0;
    cyc(30);
    base = kv_seen;
    pressed[1] = 1'b1;
    pressed[5] = 1'b1;
    cyc(60);
    check_int("two rows pulses", kv_seen - base, 0);
    pressed = '0;
    cyc(5);

    // Reset during press debounce of "F".
    pressed[14] = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        cyc(1);
        if (m_mode == 1) ok = 1'b1;
      end
      check_int("keyF reached debounce", int'(ok), 1);
    end
    cyc(3);
    base = kv_seen;
    reset = 1'b0;
    cyc(1);
    check4("midreset cols", cols, 4'b1110);
    check4("midreset key", key, 4'h0);
    check4("midreset digit0", digit0, 4'h0);
    check4("midreset digit1", digit1, 4'h0);
    check4("midreset key_valid", {3'b0, key_valid}, 4'h0);
    cyc(3);
    check_int("midreset pulses", kv_seen - base, 0);
    reset = 1'b1;
    wait_kv("keyF", 200);
    check4("keyF key", key, 4'hF);
    check4("keyF digit0", digit0, 4'hF);
    check4("keyF digit1", digit1, 4'h0);
    check_int("keyF pulses", kv_seen - base, 1);
    pressed = '0;
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
